mux_arb_2_1: RTL
================

MUX_ARB_2_1 -- requirements
Module: mux_arb_2_1

Interface
REQ-001 Parameter: MAX_BEATS, default 16, maximum beats per grant before forced release (range 1..255).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 a_data_i  input  8  requester A data.
REQ-005 a_valid_i  input  1  requester A beat valid.
REQ-006 a_last_i  input  1  requester A final beat of packet.
REQ-007 a_ready_o  output  1  requester A beat accepted this cycle when high with a_valid_i.
REQ-008 b_data_i, b_valid_i, b_last_i, b_ready_o: same as REQ-004..007, for requester B.
REQ-009 y_data_o  output  8  registered output data.
REQ-010 y_valid_o  output  1  output beat valid.
REQ-011 y_last_o  output  1  output final beat of packet, or forced-release beat.
REQ-012 y_ready_i  input  1  downstream accepts output beat.
REQ-013 grant_o  output  2  one-hot current grant: bit0 = A, bit1 = B; 00 when idle.

Function
REQ-014 FSM states IDLE, GRANT_A, GRANT_B; reset state IDLE.
REQ-015 IDLE: only A valid -> GRANT_A; only B valid -> GRANT_B; both valid -> requester holding priority; neither -> IDLE.
REQ-016 IDLE grants nothing: a_ready_o = b_ready_o = 0; first beat accepted no earlier than the cycle after the request is seen.
REQ-017 Output register free = !y_valid_o || y_ready_i.
REQ-018 a_ready_o = (state == GRANT_A) && free; b_ready_o likewise for GRANT_B; never both high.
REQ-019 Accepted beat loads y_data_o/y_last_o from the granted source and sets y_valid_o next cycle; latency is 1 cycle from accept to y_valid_o.
REQ-020 y_valid_o clears when y_ready_i is high and no new beat is accepted in the same cycle.
REQ-021 While y_valid_o = 1 and y_ready_i = 0, y_data_o and y_last_o are held stable.
REQ-022 Beat counter (8-bit) clears on entry to GRANT_x and increments on each accepted beat.
REQ-023 Release on an accepted beat with last = 1, or on an accepted beat that makes count == MAX_BEATS -> IDLE next cycle; last and limit together cause one release.
REQ-024 On a forced release, y_last_o = 1 for that beat.
REQ-025 On release, priority passes to the other requester.
REQ-026 Granted source deasserts valid mid-packet -> grant held, no beats accepted; the other requester is not served.
REQ-027 grant_o = 01 in GRANT_A, 10 in GRANT_B, 00 in IDLE.
REQ-028 Data are never duplicated or dropped except by reset.

Reset
REQ-029 rst_ni low: state IDLE, priority A, count 0, y_valid_o 0, y_data_o 0x00, y_last_o 0, grant_o 00, both ready outputs 0, all immediately (asynchronous).
REQ-030 Reset mid-packet discards the in-flight beat; after release, arbitration restarts from IDLE with priority A.

Structure
REQ-031 Package mux_arb_pkg holds: state enum typedef (arb_state_t), MAX_BEATS default constant, DATA_W = 8 constant.
REQ-032 Data select is one instance of the existing mux_2_1 (a_i = a_data_i, b_i = b_data_i, sel_i = state == GRANT_B) feeding the output register; no other sub-modules.

Verification
REQ-033 Single packet: A sends 0x11, 0x22, 0x33 (last on 0x33), y_ready_i = 1 -> y_data_o 0x11, 0x22, 0x33 on consecutive cycles, y_last_o only with 0x33, grant_o 01 then 00.
REQ-034 Contention after reset: A and B both valid, 2-beat packets -> A served first; B granted in the cycle after A's IDLE; second contention grants B first.
REQ-035 Backpressure: y_ready_i low for 4 cycles with y_data_o = 0x5A -> 0x5A stable, a_ready_o = 0, no beat lost when ready returns.
REQ-036 Forced release: MAX_BEATS = 4, B streams 6 beats with no last while A waits -> 4th B beat has y_last_o = 1, A granted next, B resumes after A's last.
REQ-037 Reset mid-packet: rst_ni low during A beat 2 of 3 -> all outputs reset immediately; after release, fresh B request granted from IDLE.
REQ-038 Idle source: A granted and drops a_valid_i for 3 cycles while B is valid -> grant_o stays 01, b_ready_o = 0 throughout.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-input packet arbiter.
//   DATA_W        : width of every data path through the arbiter
//   MAX_BEATS_DEF : default number of beats a grant may run before it is taken away
//   arb_state_t   : arbiter state encoding
//   grant_of()    : one-hot grant vector for a given state
package mux_arb_pkg;

    localparam int DATA_W        = 8;
    localparam int MAX_BEATS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    // bit0 = requester A, bit1 = requester B, zero while idle
    function automatic logic [1:0] grant_of(input arb_state_t st);
        logic [1:0] g;
        case (st)
            GRANT_A: g = 2'b01;
            GRANT_B: g = 2'b10;
            IDLE:    g = 2'b00;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mux_2_1.sv
// Plain two-way data selector.
//   a_i   : data returned when sel_i is low
//   b_i   : data returned when sel_i is high
//   sel_i : select
//   y_o   : selected data (combinational)
module mux_2_1
    import mux_arb_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sel_i,
    output logic [W-1:0] y_o
);

    // select between the two inputs
    always_comb begin
        if (sel_i) begin
            y_o = b_i;
        end else begin
            y_o = a_i;
        end
    end

endmodule

// File: rtl/mux_arb_2_1.sv
// Two-requester packet arbiter with a registered output stage.
// A grant lasts until the granted source sends a beat flagged last, or until
// MAX_BEATS beats have gone through (that beat is then flagged last on the
// output). After every release priority moves to the other requester.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   a_data_i/a_valid_i/a_last_i: requester A beat, a_ready_o accepts it
//   b_data_i/b_valid_i/b_last_i: requester B beat, b_ready_o accepts it
//   y_data_o/y_valid_o/y_last_o: registered output beat, y_ready_i drains it
//   grant_o                    : one-hot current grant (01 = A, 10 = B, 00 = idle)
module mux_arb_2_1
    import mux_arb_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_valid_i,
    input  logic              a_last_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              b_valid_i,
    input  logic              b_last_i,
    output logic              b_ready_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_valid_o,
    output logic              y_last_o,
    input  logic              y_ready_i,
    output logic [1:0]        grant_o
);

    localparam logic [7:0] MAX_BEATS_C = 8'(MAX_BEATS);

    arb_state_t        state_q, state_d;
    logic              prio_b_q, prio_b_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    logic              y_last_q, y_last_d;
    logic              y_valid_q, y_valid_d;
    logic [1:0]        grant_q, grant_d;

    logic              sel_b_s;
    logic              out_free_s;
    logic              a_ready_s;
    logic              b_ready_s;
    logic              accept_s;
    logic              src_last_s;
    logic              limit_s;
    logic              release_s;
    logic [7:0]        cnt_inc_s;
    logic [DATA_W-1:0] mux_data_s;

    mux_2_1 #(.W(DATA_W)) u_data_mux (
        .a_i   (a_data_i),
        .b_i   (b_data_i),
        .sel_i (sel_b_s),
        .y_o   (mux_data_s)
    );

    // handshake with the granted source and release detection
    always_comb begin
        sel_b_s    = (state_q == GRANT_B);
        out_free_s = !y_valid_q || y_ready_i;
        a_ready_s  = (state_q == GRANT_A) && out_free_s;
        b_ready_s  = (state_q == GRANT_B) && out_free_s;
        accept_s   = (a_ready_s && a_valid_i) || (b_ready_s && b_valid_i);
        src_last_s = sel_b_s ? b_last_i : a_last_i;
        cnt_inc_s  = cnt_q + 8'd1;
        // last and limit on the same beat still yield a single release
        limit_s    = accept_s && (cnt_inc_s == MAX_BEATS_C);
        release_s  = accept_s && (src_last_s || limit_s);
    end

    // arbitration state, priority and beat counter
    always_comb begin
        state_d  = state_q;
        prio_b_d = prio_b_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                // counter is held at zero here so every grant starts from 0
                cnt_d = 8'd0;
                if (a_valid_i && b_valid_i) begin
                    state_d = prio_b_q ? GRANT_B : GRANT_A;
                end else if (a_valid_i) begin
                    state_d = GRANT_A;
                end else if (b_valid_i) begin
                    state_d = GRANT_B;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_A, GRANT_B: begin
                if (release_s) begin
                    state_d  = IDLE;
                    prio_b_d = (state_q == GRANT_A);
                    cnt_d    = 8'd0;
                end else if (accept_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // output register: load on accept, drop valid once drained, else hold
    always_comb begin
        y_data_d  = y_data_q;
        y_last_d  = y_last_q;
        y_valid_d = y_valid_q;
        if (accept_s) begin
            y_data_d  = mux_data_s;
            y_last_d  = src_last_s || limit_s;
            y_valid_d = 1'b1;
        end else if (y_ready_i) begin
            y_valid_d = 1'b0;
        end else begin
            y_valid_d = y_valid_q;
        end
        grant_d = grant_of(state_d);
    end

    // all state elements
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            prio_b_q  <= 1'b0;
            cnt_q     <= 8'd0;
            y_data_q  <= {DATA_W{1'b0}};
            y_last_q  <= 1'b0;
            y_valid_q <= 1'b0;
            grant_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            prio_b_q  <= prio_b_d;
            cnt_q     <= cnt_d;
            y_data_q  <= y_data_d;
            y_last_q  <= y_last_d;
            y_valid_q <= y_valid_d;
            grant_q   <= grant_d;
        end
    end

    assign a_ready_o = a_ready_s;
    assign b_ready_o = b_ready_s;
    assign y_data_o  = y_data_q;
    assign y_last_o  = y_last_q;
    assign y_valid_o = y_valid_q;
    assign grant_o   = grant_q;

endmodule
